// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
//   arb_state_t : arbitration state (CPU priority, forced debug slot, debug lock)
//   owner_t     : which requester an in-flight load belongs to
//   mem_req_t   : request bundle {we, addr, wdata} at the default widths
//   is_misaligned() : true when a byte address is not word aligned
package dmem_arb_pkg;

    localparam int ADDR_W_DFLT = 7;
    localparam int DATA_W_DFLT = 32;

    typedef enum logic [1:0] {
        S_CPU_PRI  = 2'b00,
        S_DBG_PRI  = 2'b01,
        S_DBG_LOCK = 2'b10
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    typedef struct packed {
        logic                   we;
        logic [ADDR_W_DFLT-1:0] addr;
        logic [DATA_W_DFLT-1:0] wdata;
    } mem_req_t;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_rsp_track.sv
// One-deep load response tracker.
// Remembers who owns the load issued last cycle and whether it was misaligned,
// then steers the memory read data (or zero for a misaligned load) to that
// requester's rvalid/rdata pair. Each requester's rdata holds its last value
// until its next rvalid.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   issue, owner, misaligned : a load is granted this cycle, its owner, bad alignment
//   mem_rdata              : synchronous memory read data
//   cpu_rvalid/cpu_rdata   : CPU response
//   dbg_rvalid/dbg_rdata   : debug response
module dmem_rsp_track
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  owner_t            owner,
    input  logic              misaligned,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata
);

    logic              pend_valid_r;
    owner_t            pend_owner_r;
    logic              pend_mis_r;
    logic [DATA_W-1:0] cpu_hold_r;
    logic [DATA_W-1:0] dbg_hold_r;
    logic [DATA_W-1:0] rsp_data_s;

    // A misaligned load never touched memory, so it returns zero.
    assign rsp_data_s = pend_mis_r ? {DATA_W{1'b0}} : mem_rdata;

    assign cpu_rvalid = pend_valid_r & (pend_owner_r == OWN_CPU);
    assign dbg_rvalid = pend_valid_r & (pend_owner_r == OWN_DBG);

    // Fresh data is visible in the rvalid cycle itself; otherwise the held copy.
    assign cpu_rdata = cpu_rvalid ? rsp_data_s : cpu_hold_r;
    assign dbg_rdata = dbg_rvalid ? rsp_data_s : dbg_hold_r;

    // In-flight load bookkeeping and per-requester read data hold registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_r <= 1'b0;
            pend_owner_r <= OWN_CPU;
            pend_mis_r   <= 1'b0;
            cpu_hold_r   <= {DATA_W{1'b0}};
            dbg_hold_r   <= {DATA_W{1'b0}};
        end else begin
            pend_valid_r <= issue;
            pend_owner_r <= owner;
            pend_mis_r   <= misaligned;
            if (cpu_rvalid) begin
                cpu_hold_r <= rsp_data_s;
            end else begin
                cpu_hold_r <= cpu_hold_r;
            end
            if (dbg_rvalid) begin
                dbg_hold_r <= rsp_data_s;
            end else begin
                dbg_hold_r <= dbg_hold_r;
            end
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbiter sharing the single-port 128-byte data memory between the pipeline
// MEM stage and a debug/loader port. The CPU has priority; a starvation
// counter forces a debug slot after MAX_WAIT consecutive denials, and a lock
// mode lets debug keep the port for up to BURST_MAX back-to-back grants.
// Grants are combinational and issue to memory in the same cycle.
// Ports:
//   clk_i, rst_i                  : clock, asynchronous active-low reset
//   cpu_* (req/we/addr/wdata in)  : MEM-stage request; gnt/rvalid/rdata/stall out
//   dbg_* (req/we/lock/addr/wdata): debug request; gnt/rvalid/rdata out
//   mem_* (en/we/addr/wdata out, rdata in) : data memory interface
//   err_o                         : pulse on a granted misaligned access
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DFLT,
    parameter int DATA_W    = DATA_W_DFLT,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic              dbg_lock_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o
);

    localparam int               CNT_W      = 4;
    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] BURST_C    = CNT_W'(BURST_MAX);
    // With a one-grant burst the entry grant is already the last, so no lock.
    localparam logic             LOCK_OK    = (BURST_MAX > 1) ? 1'b1 : 1'b0;

    arb_state_t       state_r, state_nxt_s;
    logic [CNT_W-1:0] wait_cnt_r, wait_cnt_nxt_s, wait_inc_s;
    logic [CNT_W-1:0] burst_cnt_r, burst_cnt_nxt_s, burst_inc_s;
    logic             cpu_req_s, dbg_req_s;
    logic             cpu_gnt_s, dbg_gnt_s, granted_s, mis_s;
    mem_req_t         cpu_bundle_s, dbg_bundle_s, win_s;

    // Requests are masked while in reset so every output reads zero.
    assign cpu_req_s   = cpu_req_i & rst_i;
    assign dbg_req_s   = dbg_req_i & rst_i;
    assign wait_inc_s  = wait_cnt_r + CNT_W'(1);
    assign burst_inc_s = burst_cnt_r + CNT_W'(1);

    // Grant selection, next state and counter updates.
    always_comb begin
        state_nxt_s     = state_r;
        burst_cnt_nxt_s = burst_cnt_r;
        wait_cnt_nxt_s  = {CNT_W{1'b0}};
        cpu_gnt_s       = 1'b0;
        dbg_gnt_s       = 1'b0;
        case (state_r)
            S_CPU_PRI: begin
                cpu_gnt_s = cpu_req_s;
                dbg_gnt_s = dbg_req_s & ~cpu_req_s;
                if (dbg_gnt_s && dbg_lock_i && LOCK_OK) begin
                    state_nxt_s     = S_DBG_LOCK;
                    burst_cnt_nxt_s = CNT_W'(1);
                end else if (dbg_req_s && !dbg_gnt_s && (wait_inc_s == MAX_WAIT_C)) begin
                    state_nxt_s = S_DBG_PRI;
                end else begin
                    state_nxt_s = S_CPU_PRI;
                end
            end
            S_DBG_PRI: begin
                if (dbg_req_s) begin
                    dbg_gnt_s = 1'b1;
                    if (dbg_lock_i && LOCK_OK) begin
                        state_nxt_s     = S_DBG_LOCK;
                        burst_cnt_nxt_s = CNT_W'(1);
                    end else begin
                        state_nxt_s = S_CPU_PRI;
                    end
                end else begin
                    cpu_gnt_s   = cpu_req_s;
                    state_nxt_s = S_CPU_PRI;
                end
            end
            S_DBG_LOCK: begin
                if (dbg_req_s && dbg_lock_i) begin
                    dbg_gnt_s = 1'b1;
                    // Reaching BURST_MAX makes this grant the last of the burst.
                    if (burst_inc_s == BURST_C) begin
                        state_nxt_s     = S_CPU_PRI;
                        burst_cnt_nxt_s = {CNT_W{1'b0}};
                    end else begin
                        state_nxt_s     = S_DBG_LOCK;
                        burst_cnt_nxt_s = burst_inc_s;
                    end
                end else begin
                    cpu_gnt_s       = cpu_req_s;
                    state_nxt_s     = S_CPU_PRI;
                    burst_cnt_nxt_s = {CNT_W{1'b0}};
                end
            end
            default: begin
                state_nxt_s     = S_CPU_PRI;
                burst_cnt_nxt_s = {CNT_W{1'b0}};
            end
        endcase
        // Starvation counter: counts consecutive denied debug cycles, saturating.
        if (dbg_req_s && !dbg_gnt_s) begin
            wait_cnt_nxt_s = (wait_cnt_r == MAX_WAIT_C) ? wait_cnt_r : wait_inc_s;
        end else begin
            wait_cnt_nxt_s = {CNT_W{1'b0}};
        end
    end

    // Arbitration state and counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= S_CPU_PRI;
            wait_cnt_r  <= {CNT_W{1'b0}};
            burst_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            wait_cnt_r  <= wait_cnt_nxt_s;
            burst_cnt_r <= burst_cnt_nxt_s;
        end
    end

    assign cpu_bundle_s = '{we: cpu_we_i, addr: cpu_addr_i, wdata: cpu_wdata_i};
    assign dbg_bundle_s = '{we: dbg_we_i, addr: dbg_addr_i, wdata: dbg_wdata_i};

    // Winner's request bundle; all zero when nobody is granted.
    always_comb begin
        win_s = '0;
        if (cpu_gnt_s) begin
            win_s = cpu_bundle_s;
        end else if (dbg_gnt_s) begin
            win_s = dbg_bundle_s;
        end else begin
            win_s = '0;
        end
    end

    assign granted_s = cpu_gnt_s | dbg_gnt_s;
    // A misaligned access is still granted but kept off the memory.
    assign mis_s     = granted_s & is_misaligned(win_s.addr[1:0]);

    assign cpu_gnt_o   = cpu_gnt_s;
    assign dbg_gnt_o   = dbg_gnt_s;
    assign cpu_stall_o = cpu_req_s & ~cpu_gnt_s;
    assign mem_en_o    = granted_s & ~mis_s;
    assign mem_we_o    = mem_en_o & win_s.we;
    assign mem_addr_o  = {win_s.addr[ADDR_W-1:2], 2'b00};
    assign mem_wdata_o = mem_we_o ? win_s.wdata : {DATA_W{1'b0}};
    assign err_o       = mis_s;

    dmem_rsp_track #(
        .DATA_W (DATA_W)
    ) u_rsp_track (
        .clk        (clk_i),
        .rst_n      (rst_i),
        .issue      (granted_s & ~win_s.we),
        .owner      (dbg_gnt_s ? OWN_DBG : OWN_CPU),
        .misaligned (mis_s),
        .mem_rdata  (mem_rdata_i),
        .cpu_rvalid (cpu_rvalid_o),
        .cpu_rdata  (cpu_rdata_o),
        .dbg_rvalid (dbg_rvalid_o),
        .dbg_rdata  (dbg_rdata_o)
    );

endmodule
